keypad_matrix_emulator: RTL and testbench
=========================================

// Module: keypad_matrix_emulator
// PURPOSE
//  Synthesizable stand-in for the 4x4 membrane keypad: answers keypad_scanner's column drive with
//  the row pattern of one emulated key, including randomized contact bounce on press and release.
//  Sits between debug buttons/bench and the scanner's keypad_column/keypad_row pins; lets the
//  scan+debounce path be exercised on the board and in sim without a physical keypad.
// PARAMETERS
//  BOUNCE_CYCLES  2000      clk cycles of bounce window on press and on release (0 = clean edge)
//  BOUNCE_STEP    50        clk cycles between contact re-samples inside bounce window (>=1)
//  LFSR_SEED      16'hACE1  nonzero seed loaded into bounce LFSR at reset
// PORTS
//  clk            in   1  system clock (HSOSC domain)
//  reset          in   1  asynchronous reset, active-low (asserted when 0)
//  keypad_column  in   4  column drive from scanner, active-low (0 = column being scanned)
//  keypad_row     out  4  row sense to scanner, active-low, idle 4'b1111
//  press_req      in   1  level: 1 = hold key down, 0 = release
//  key_code       in   4  key to emulate: row = key_code[3:2], column = key_code[1:0]
//  busy           out  1  1 in any state other than IDLE
//  contact        out  1  instantaneous emulated contact state (debug LED)
//  done           out  1  1-cycle pulse on BOUNCE_RELEASE -> IDLE
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, keypad_row=4'b1111, busy=0, contact=0, done=0,
//   latched key=0, counters=0, LFSR=LFSR_SEED. Outputs held for the whole time reset is low.
//  FSM: IDLE, BOUNCE_PRESS, HELD, BOUNCE_RELEASE.
//   IDLE: press_req=1 at edge N -> latch key_code, BOUNCE_PRESS from N+1 (HELD if BOUNCE_CYCLES=0).
//   BOUNCE_PRESS: counts BOUNCE_CYCLES cycles -> HELD; press_req=0 at any cycle -> BOUNCE_RELEASE,
//    window counter restarts from 0.
//   HELD: contact=1 steady; press_req=0 -> BOUNCE_RELEASE (IDLE if BOUNCE_CYCLES=0, done pulses).
//   BOUNCE_RELEASE: counts BOUNCE_CYCLES cycles -> IDLE with done=1 for that one cycle;
//    press_req ignored here. Back in IDLE, press_req still 1 starts a new press next edge.
//  key_code is sampled only on IDLE exit; changes while busy are ignored.
//  Bounce: step counter wraps every BOUNCE_STEP cycles; on wrap LFSR advances one step and
//   contact <= lfsr[0]. First bounce cycle contact=1 (press) / 0 (release). contact=1 in HELD,
//   0 in IDLE regardless of LFSR.
//  LFSR: 16-bit Galois, mask 16'hB400, shift right; advances only on bounce-step wraps; never 0.
//  Row output (registered, 1-cycle latency): keypad_row[r] <= ~(contact && r==key_row &&
//   keypad_column[key_col]==0). Multiple columns low: row asserts if the key's column is among
//   them. keypad_column is used only inside the row register (scanner drives it from clk domain).
//  busy is registered: 1 from the cycle after IDLE exit through the cycle before IDLE re-entry.
//  Counters sized $clog2(BOUNCE_CYCLES+1) / $clog2(BOUNCE_STEP+1); no overflow paths.
// STRUCTURE
//  keypad_pkg: emu_state_t enum, key_code_t (logic[3:0]), KEY_ROW/KEY_COL field helpers,
//   LFSR_MASK=16'hB400; shared with keypad_scanner for consistent code mapping.
//  One sub-module: lfsr16 (clk, reset, advance, seed, q[15:0]); FSM, counters, row register top.
// TESTING
//  1 Reset: hold reset=0 with press_req=1 -> keypad_row=1111, busy=0, contact=0 throughout.
//  2 BOUNCE_CYCLES=0, key_code=4'h6, press_req=1, columns 1011 -> keypad_row=1101 two edges
//    after press_req; columns 1110/1101/0111 -> 1111; columns 0011 -> 1101.
//  3 Defaults, key 4'hF: contact toggles >=1 time in bounce window; HELD and contact=1 exactly
//    BOUNCE_CYCLES cycles after BOUNCE_PRESS entry; release -> done pulse 2000 cycles later, busy=0.
//  4 Drop press_req 300 cycles into BOUNCE_PRESS -> BOUNCE_RELEASE immediately, IDLE after 2000
//    more cycles, one done pulse; change key_code mid-press -> row pattern unchanged.
//  5 Async reset=0 mid-HELD (between edges) -> keypad_row=1111, busy=0 before next clk edge.
//  6 Loop into keypad_scanner (BOUNCE_CYCLES < debounce_delay): each key 0..F -> exactly one
//    new_value, pressed_value == key_code.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator and scanner: FSM states,
// key code layout and the bounce LFSR feedback mask.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE           = 2'd0,
        ST_BOUNCE_PRESS   = 2'd1,
        ST_HELD           = 2'd2,
        ST_BOUNCE_RELEASE = 2'd3
    } emu_state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Row index of a key lives in the upper two bits of the code
    function automatic logic [1:0] KEY_ROW(input key_code_t k);
        return k[3:2];
    endfunction

    // Column index of a key lives in the lower two bits of the code
    function automatic logic [1:0] KEY_COL(input key_code_t k);
        return k[1:0];
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_lfsr16.sv
// 16-bit right-shifting Galois LFSR that supplies pseudo-random contact
// samples during bounce windows. Steps only when asked to.
module lfsr16
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic [15:0] w_next;

    assign w_next = r_q[0] ? ((r_q >> 1) ^ LFSR_MASK) : (r_q >> 1);

    // Load the seed on reset, otherwise step once per advance request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= seed;
        end else if (advance) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 active-low membrane keypad, including contact
// bounce on press and release, answering the scanner's column drive with
// a registered row pattern.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 2000,
    parameter int          BOUNCE_STEP   = 50,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_column,
    output logic [3:0] keypad_row,
    input  logic       press_req,
    input  logic [3:0] key_code,
    output logic       busy,
    output logic       contact,
    output logic       done
);

    // A zero-length window still needs a one-bit counter to keep widths legal
    localparam int CNT_W  = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int STEP_W = $clog2(BOUNCE_STEP + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BOUNCE_STEP - 1);
    localparam bit CLEAN = (BOUNCE_CYCLES == 0);

    emu_state_t        r_state;
    emu_state_t        w_state_next;
    key_code_t         r_key;
    logic [CNT_W-1:0]  r_cnt;
    logic [STEP_W-1:0] r_step;
    logic              r_contact;
    logic              w_contact_next;
    logic              r_busy;
    logic              r_done;
    logic              w_done_next;
    logic [3:0]        r_row;
    logic [3:0]        w_row_next;
    logic [15:0]       w_lfsr_q;
    logic [14:0]       w_lfsr_unused;
    logic              w_in_bounce;
    logic              w_step_wrap;
    logic              w_window_end;
    logic              w_state_change;
    logic              w_advance;
    logic              w_next_bounce;

    assign w_in_bounce    = (r_state == ST_BOUNCE_PRESS) || (r_state == ST_BOUNCE_RELEASE);
    assign w_step_wrap    = (r_step == STEP_LAST);
    assign w_window_end   = (r_cnt == CNT_LAST);
    assign w_state_change = (w_state_next != r_state);
    assign w_next_bounce  = (w_state_next == ST_BOUNCE_PRESS) || (w_state_next == ST_BOUNCE_RELEASE);
    // Re-sample only while staying in the same window; the closing edge of a
    // window sets contact from the new state instead.
    assign w_advance      = w_in_bounce && w_step_wrap && !w_state_change;
    assign w_lfsr_unused  = w_lfsr_q[15:1];

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_advance),
        .seed    (LFSR_SEED),
        .q       (w_lfsr_q)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, done pulse and contact decisions
    always_comb begin
        w_state_next   = r_state;
        w_done_next    = 1'b0;
        w_contact_next = r_contact;
        case (r_state)
            ST_IDLE: begin
                if (press_req) begin
                    w_state_next = CLEAN ? ST_HELD : ST_BOUNCE_PRESS;
                end
            end
            ST_BOUNCE_PRESS: begin
                if (!press_req) begin
                    w_state_next = ST_BOUNCE_RELEASE;
                end else if (w_window_end) begin
                    w_state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!press_req) begin
                    w_state_next = CLEAN ? ST_IDLE : ST_BOUNCE_RELEASE;
                    w_done_next  = CLEAN;
                end
            end
            ST_BOUNCE_RELEASE: begin
                if (w_window_end) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        case (w_state_next)
            ST_IDLE:           w_contact_next = 1'b0;
            ST_HELD:           w_contact_next = 1'b1;
            ST_BOUNCE_PRESS:   w_contact_next = w_state_change ? 1'b1 : (w_advance ? w_lfsr_q[0] : r_contact);
            ST_BOUNCE_RELEASE: w_contact_next = w_state_change ? 1'b0 : (w_advance ? w_lfsr_q[0] : r_contact);
            default:           w_contact_next = 1'b0;
        endcase
    end

    // Row sense per row line: pull low only when the emulated key connects
    // this row to a currently driven column
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign w_row_next[gi] = ~(r_contact && (KEY_ROW(r_key) == 2'(gi)) &&
                                      !keypad_column[KEY_COL(r_key)]);
        end
    endgenerate

    // Datapath: key latch, window/step counters, contact, flags and row register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key     <= '0;
            r_cnt     <= '0;
            r_step    <= '0;
            r_contact <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_row     <= 4'b1111;
        end else begin
            if (r_state == ST_IDLE && press_req) begin
                r_key <= key_code;
            end
            if (w_next_bounce && !w_state_change) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_step <= w_step_wrap ? '0 : r_step + STEP_W'(1);
            end else begin
                r_cnt  <= '0;
                r_step <= '0;
            end
            r_contact <= w_contact_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= w_done_next;
            r_row     <= w_row_next;
        end
    end

    assign keypad_row = r_row;
    assign busy       = r_busy;
    assign contact    = r_contact;
    assign done       = r_done;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for the keypad emulator: a clean-edge instance
// (BOUNCE_CYCLES=0) and a default-parameter instance share all inputs.
module tb_keypad_matrix_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keypad_column = 4'b0000;
    logic       press_req = 1'b1;
    logic [3:0] key_code = 4'hF;

    logic [3:0] row0, row1;
    logic       busy0, busy1, contact0, contact1, done0, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(.BOUNCE_CYCLES(0)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .keypad_column (keypad_column),
        .keypad_row    (row0),
        .press_req     (press_req),
        .key_code      (key_code),
        .busy          (busy0),
        .contact       (contact0),
        .done          (done0)
    );

    keypad_matrix_emulator dut1 (
        .clk           (clk),
        .reset         (reset),
        .keypad_column (keypad_column),
        .keypad_row    (row1),
        .press_req     (press_req),
        .key_code      (key_code),
        .busy          (busy1),
        .contact       (contact1),
        .done          (done1)
    );

    // Reference Galois step: shift right, xor mask when the bit shifted out is 1
    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        press_req = 1'b0;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        reset = 1'b0;
        press_req = 1'b1;
        key_code = 4'hF;
        keypad_column = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (row0 !== 4'b1111 || busy0 !== 1'b0 || contact0 !== 1'b0 || done0 !== 1'b0 ||
                row1 !== 4'b1111 || busy1 !== 1'b0 || contact1 !== 1'b0 || done1 !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_hold: %0d cycles with non-idle outputs, required 0", bad);
        end
        checks++;
        if (row1 !== 4'b1111) begin
            errors++;
            $display("FAIL reset_row: got %b required 1111", row1);
        end
        $display("test_reset: done");
    endtask

    task automatic test_clean_edge;
        press_req = 1'b0;
        reset = 1'b1;
        key_code = 4'h6;
        keypad_column = 4'b1011;
        step(2);
        press_req = 1'b1;
        step(1);
        checks++;
        if (row0 !== 4'b1111) begin
            errors++;
            $display("FAIL clean_row_latency: got %b required 1111 one edge after press", row0);
        end
        checks++;
        if (busy0 !== 1'b1 || contact0 !== 1'b1) begin
            errors++;
            $display("FAIL clean_held: busy=%b contact=%b required 1 1", busy0, contact0);
        end
        step(1);
        checks++;
        if (row0 !== 4'b1101) begin
            errors++;
            $display("FAIL clean_row_col2: got %b required 1101", row0);
        end
        keypad_column = 4'b1110;
        step(1);
        checks++;
        if (row0 !== 4'b1111) begin
            errors++;
            $display("FAIL clean_row_col0: got %b required 1111", row0);
        end
        keypad_column = 4'b1101;
        step(1);
        checks++;
        if (row0 !== 4'b1111) begin
            errors++;
            $display("FAIL clean_row_col1: got %b required 1111", row0);
        end
        keypad_column = 4'b0111;
        step(1);
        checks++;
        if (row0 !== 4'b1111) begin
            errors++;
            $display("FAIL clean_row_col3: got %b required 1111", row0);
        end
        keypad_column = 4'b0011;
        step(1);
        checks++;
        if (row0 !== 4'b1101) begin
            errors++;
            $display("FAIL clean_row_multi: got %b required 1101", row0);
        end
        press_req = 1'b0;
        step(1);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || contact0 !== 1'b0) begin
            errors++;
            $display("FAIL clean_release: done=%b busy=%b contact=%b required 1 0 0", done0, busy0, contact0);
        end
        step(1);
        checks++;
        if (done0 !== 1'b0 || row0 !== 4'b1111) begin
            errors++;
            $display("FAIL clean_after_release: done=%b row=%b required 0 1111", done0, row0);
        end
        $display("test_clean_edge: done");
    endtask

    task automatic test_bounce_hold;
        logic [15:0] m;
        logic        exp_c;
        logic        prev_c;
        logic        obs_prev;
        int          bad;
        int          toggles;
        apply_reset();
        key_code = 4'hF;
        keypad_column = 4'b0111;
        step(2);
        press_req = 1'b1;
        step(1);
        m = 16'hACE1;
        exp_c = 1'b1;
        prev_c = 1'b0;
        obs_prev = contact1;
        bad = 0;
        toggles = 0;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) begin
                step(1);
                if (k % 50 == 0) begin
                    exp_c = m[0];
                    m = lfsr_ref(m);
                end
                if (contact1 !== obs_prev) toggles++;
                obs_prev = contact1;
            end
            if (contact1 !== exp_c || busy1 !== 1'b1 || done1 !== 1'b0 ||
                row1 !== (prev_c ? 4'b0111 : 4'b1111))
                bad++;
            prev_c = exp_c;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL press_bounce_pattern: %0d cycles off reference, required 0", bad);
        end
        checks++;
        if (toggles < 1) begin
            errors++;
            $display("FAIL press_bounce_toggles: got %0d required >=1", toggles);
        end
        step(1);
        checks++;
        if (contact1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL held_entry: contact=%b busy=%b required 1 1", contact1, busy1);
        end
        step(1);
        checks++;
        if (row1 !== 4'b0111) begin
            errors++;
            $display("FAIL held_row: got %b required 0111", row1);
        end
        step(20);
        press_req = 1'b0;
        step(1);
        exp_c = 1'b0;
        prev_c = 1'b1;
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) begin
                step(1);
                if (k % 50 == 0) begin
                    exp_c = m[0];
                    m = lfsr_ref(m);
                end
            end
            if (contact1 !== exp_c || busy1 !== 1'b1 || done1 !== 1'b0 ||
                row1 !== (prev_c ? 4'b0111 : 4'b1111))
                bad++;
            prev_c = exp_c;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL release_bounce_pattern: %0d cycles off reference, required 0", bad);
        end
        step(1);
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || contact1 !== 1'b0) begin
            errors++;
            $display("FAIL release_done: done=%b busy=%b contact=%b required 1 0 0", done1, busy1, contact1);
        end
        step(1);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %b required 0", done1);
        end
        $display("test_bounce_hold: done");
    endtask

    task automatic test_abort_press;
        int bad;
        int pulses;
        apply_reset();
        key_code = 4'h5;
        keypad_column = 4'b1101;
        step(2);
        press_req = 1'b1;
        step(1);
        bad = 0;
        for (int k = 1; k < 300; k++) begin
            step(1);
            if (k == 10) key_code = 4'hA;
            if (k == 20) begin
                checks++;
                if (row1 !== 4'b1101) begin
                    errors++;
                    $display("FAIL abort_key_kept: got %b required 1101", row1);
                end
            end
            if (busy1 !== 1'b1 || (row1 !== 4'b1101 && row1 !== 4'b1111)) bad++;
        end
        press_req = 1'b0;
        step(1);
        checks++;
        if (contact1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_enter_release: contact=%b busy=%b required 0 1", contact1, busy1);
        end
        pulses = 0;
        for (int j = 1; j <= 2000; j++) begin
            step(1);
            if (j == 700) press_req = 1'b1;
            if (done1 === 1'b1) pulses++;
            if (j < 2000 && (busy1 !== 1'b1 || done1 !== 1'b0)) bad++;
            if (row1 !== 4'b1101 && row1 !== 4'b1111) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_window: %0d bad cycles, required 0", bad);
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_time: done=%b busy=%b required 1 0", done1, busy1);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL abort_done_count: got %0d required 1", pulses);
        end
        keypad_column = 4'b1011;
        step(1);
        checks++;
        if (busy1 !== 1'b1 || contact1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL repress: busy=%b contact=%b done=%b required 1 1 0", busy1, contact1, done1);
        end
        step(1);
        checks++;
        if (row1 !== 4'b1011) begin
            errors++;
            $display("FAIL repress_new_key: got %b required 1011", row1);
        end
        $display("test_abort_press: done");
    endtask

    task automatic test_async_reset;
        apply_reset();
        key_code = 4'h6;
        keypad_column = 4'b1011;
        press_req = 1'b1;
        step(3);
        checks++;
        if (row0 !== 4'b1101 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL async_precondition: row=%b busy=%b required 1101 1", row0, busy0);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (row0 !== 4'b1111 || busy0 !== 1'b0 || contact0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_clean: row=%b busy=%b contact=%b required 1111 0 0", row0, busy0, contact0);
        end
        checks++;
        if (busy1 !== 1'b0 || contact1 !== 1'b0 || row1 !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset_bounce: row=%b busy=%b contact=%b required 1111 0 0", row1, busy1, contact1);
        end
        press_req = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);
        $display("test_async_reset: done");
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce_hold();
        test_abort_press();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
